// File: rtl/seq_gen_tx_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
// Imported by the interface, the shift register and the control block.
package seq_gen_tx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_gen_tx_if.sv
// Control/data bundle between a pattern source and the transmitter.
// master drives the request fields, slave returns the serial stream.
interface seq_gen_tx_if
  import seq_gen_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] patLen;
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gapLen;
  logic             serOut;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, patLen,
    output reps, gapLen,
    input  serOut, busy, done
  );

  modport slave (
    input  start, pattern, patLen,
    input  reps, gapLen,
    output serOut, busy, done
  );

endinterface

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register; load aligns bit len-1 to the MSB.
// o_load_msb exposes the first bit of the word being loaded.
module seq_shift_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_load_msb,
  output logic             o_msb
);

  logic [LEN_W-1:0] w_sh;
  logic [WIDTH-1:0] w_aligned;
  logic [WIDTH-1:0] r_q;

  assign w_sh       = LEN_W'(WIDTH) - i_len;
  assign w_aligned  = i_din << w_sh;
  assign o_load_msb = w_aligned[WIDTH-1];
  assign o_msb      = r_q[WIDTH-1];

  // The MSB goes out on load, so keep only the bits still to send.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= w_aligned << 1;
    end else if (i_shift) begin
      r_q <= r_q << 1;
    end
  end

endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: MSB-first, with repeat count and idle gap.
// Control FSM and counters; bit storage lives in seq_shift_reg.
module seq_gen_tx
  import seq_gen_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic         clk,
  input  logic         rst,
  seq_gen_tx_if.slave  bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [GAP_W-1:0] r_gap;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [REP_W-1:0] r_rep_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_len_eff;
  logic [REP_W-1:0] w_reps_eff;
  logic             w_accept;
  logic             w_reload;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_din;
  logic [LEN_W-1:0] w_dlen;
  logic             w_load_msb;
  logic             w_msb;

  always_comb begin
    w_len_eff = bus.patLen;
    if (bus.patLen == '0 || int'(bus.patLen) > WIDTH)
      w_len_eff = LEN_W'(WIDTH);
  end

  assign w_reps_eff = (bus.reps == '0) ? REP_W'(1) : bus.reps;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_reload =
    ((r_state == S_SHIFT) && (r_bit_cnt == '0) &&
     (r_rep_cnt != '0) && (r_gap == '0)) ||
    ((r_state == S_GAP) && (r_gap_cnt == '0));
  assign w_load  = w_accept || w_reload;
  assign w_shift = (r_state == S_SHIFT) && (r_bit_cnt != '0);
  assign w_din   = w_accept ? bus.pattern : r_pat;
  assign w_dlen  = w_accept ? w_len_eff : r_len;

  seq_shift_reg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_sreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_din      (w_din),
    .i_len      (w_dlen),
    .o_load_msb (w_load_msb),
    .o_msb      (w_msb)
  );

  // Counters hold "remaining after the current one", so zero is terminal.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_gap     <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap_cnt <= '0;
      r_ser     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ser <= 1'b0;
          if (bus.start) begin
            r_pat     <= bus.pattern;
            r_len     <= w_len_eff;
            r_gap     <= bus.gapLen;
            r_bit_cnt <= w_len_eff - 1'b1;
            r_rep_cnt <= w_reps_eff - 1'b1;
            r_ser     <= w_load_msb;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_bit_cnt != '0) begin
            r_ser     <= w_msb;
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end else if (r_rep_cnt == '0) begin
            r_ser   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_gap == '0) begin
            r_ser     <= w_load_msb;
            r_bit_cnt <= r_len - 1'b1;
            r_rep_cnt <= r_rep_cnt - 1'b1;
          end else begin
            r_ser     <= 1'b0;
            r_gap_cnt <= r_gap - 1'b1;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end else begin
            r_ser     <= w_load_msb;
            r_bit_cnt <= r_len - 1'b1;
            r_rep_cnt <= r_rep_cnt - 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.serOut = r_ser;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Self-checking bench for seq_gen_tx: per-cycle {serOut,busy,done}
// expectations are queued at launch and popped as cycles elapse.
module tb_seq_gen_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_gen_tx_if bus ();

  seq_gen_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got;
  logic [2:0] want;
  logic [3:0] win;
  int         hits;

  task automatic push_model(input logic [7:0] p, input int pl,
                            input int rp, input int gp);
    int el;
    int er;
    el = (pl == 0 || pl > 8) ? 8 : pl;
    er = (rp == 0) ? 1 : rp;
    for (int r = 0; r < er; r++) begin
      for (int b = el - 1; b >= 0; b--)
        exp_q.push_back({p[b], 1'b1, 1'b0});
      if (r < er - 1)
        repeat (gp) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
  endtask

  task automatic apply(input logic [7:0] p, input logic [3:0] l,
                       input logic [3:0] r, input logic [3:0] g);
    bus.pattern = p;
    bus.patLen  = l;
    bus.reps    = r;
    bus.gapLen  = g;
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [3:0] g);
    apply(p, l, r, g);
    bus.start = 1'b1;
    push_model(p, int'(l), int'(r), int'(g));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    apply(8'h00, 4'd0, 4'd0, 4'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    got = {bus.serOut, bus.busy, bus.done};
    total++;
    if (got !== 3'b000) begin
      bad++;
      $display("FAIL reset got=%b want=000", got);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    launch(8'b1011_0110, 4'd8, 4'd1, 4'd0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL basic c%0d got=%b want=%b", k, got, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gap();
    int nb;
    nb = 0;
    launch(8'h05, 4'd3, 4'd3, 4'd2);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      if (got[1]) nb++;
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL gap c%0d got=%b want=%b", k, got, want);
      end
      @(negedge clk);
    end
    total++;
    if (nb !== 14) begin
      bad++;
      $display("FAIL gap_busy got=%0d want=14", nb);
    end
  endtask

  task automatic test_back_to_back();
    launch(8'h0C, 4'd4, 4'd2, 4'd0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b c%0d got=%b want=%b", k, got, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bounds();
    launch(8'hA5, 4'd0, 4'd0, 4'd0);
    launch_drain("len0");
    launch(8'h5A, 4'd12, 4'd1, 4'd0);
    launch_drain("len12");
    launch(8'h01, 4'd1, 4'd15, 4'd0);
    launch_drain("rep15");
    launch(8'h02, 4'd2, 4'd2, 4'd15);
    launch_drain("gap15");
  endtask

  task automatic launch_drain(input string nm);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s c%0d got=%b want=%b", nm, k, got, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_restart();
    launch(8'b1011_0110, 4'd8, 4'd1, 4'd0);
    push_model(8'h3C, 8, 1, 0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL restart c%0d got=%b want=%b", k, got, want);
      end
      if (k == 3 || k == 9) begin
        apply(8'h4B, 4'd3, 4'd5, 4'd7);
        bus.start = 1'b1;
      end else if (k == 10) begin
        apply(8'h3C, 4'd8, 4'd1, 4'd0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    launch(8'b1011_0110, 4'd8, 4'd1, 4'd0);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    repeat (3) exp_q.push_back(3'b000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rst_mid c%0d got=%b want=%b", k, got, want);
      end
      rst = (k == 4);
      @(negedge clk);
    end
    rst = 1'b0;
    launch(8'h96, 4'd8, 4'd1, 4'd0);
    launch_drain("after_rst");
  endtask

  task automatic test_loopback();
    win  = 4'b0000;
    hits = 0;
    launch(8'h0D, 4'd4, 4'd3, 4'd2);
    for (int k = 1; exp_q.size() > 0; k++) begin
      want = exp_q.pop_front();
      got  = {bus.serOut, bus.busy, bus.done};
      win  = {win[2:0], got[2]};
      if (win == 4'b1101) hits++;
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL loop c%0d got=%b want=%b", k, got, want);
      end
      @(negedge clk);
    end
    total++;
    if (hits !== 3) begin
      bad++;
      $display("FAIL loop_hits got=%0d want=3", hits);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    apply(8'h00, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_bounds();
    test_restart();
    test_rst_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
